// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared defaults and helpers for the multi-channel PWM generator.
//   CH_NUM_DEF      default channel count
//   CNT_W_DEF       default width of counter, period and duty values
//   PRESCALE_W_DEF  default width of the prescaler divide value
//   cnt_t           counter value at the default width
//   duty_arr_t      packed duty array at the default widths (channel 0 in LSBs)
//   chan_lsb()      LSB position of a channel inside the packed duty bus
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int CH_NUM_DEF     = 4;
    localparam int CNT_W_DEF      = 8;
    localparam int PRESCALE_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0]                 cnt_t;
    typedef logic [CH_NUM_DEF-1:0][CNT_W_DEF-1:0] duty_arr_t;

    // Channel ch occupies duty[chan_lsb(ch, w) +: w].
    function automatic int chan_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Divides clk down to a one-cycle tick every prescale+1 cycles. The divide
// value is used live; if it drops below the running count, the count runs on
// to its all-ones value and wraps naturally to 0.
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   low holds the count at 0 and suppresses tick
//   prescale  in   divide value (tick period = prescale+1 cycles)
//   tick      out  combinational, high in the cycle where count == prescale
// -----------------------------------------------------------------------------
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] PS_ONE = 1;

    logic [PRESCALE_W-1:0] count_q, count_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        tick    = en && (count_q == prescale);
        count_d = count_q + PS_ONE;
        if (!en || tick) begin
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
// One shared prescaler and period counter driving CH_NUM duty comparators.
// Duty values are double-buffered (shadow -> active) and the period value is
// captured into the active register only at a period boundary, so outputs
// never glitch mid-period. While en is low the counters sit at 0, outputs are
// low, and the active registers track the shadow duty and period input.
//
// Optional feature macro: PWM_CENTER_ALIGN_EN
//   undefined : edge-aligned sawtooth 0..P, period P+1 ticks
//   defined   : up/down count 0..P..1, period 2*P ticks (1 tick when P=0)
//
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   run enable
//   prescale    in   tick divider (tick every prescale+1 cycles)
//   period      in   counter top value, sampled at period boundaries
//   duty        in   packed duty values, channel i at [i*CNT_W +: CNT_W]
//   duty_wr     in   strobe: load all of duty into the shadow registers
//   pwm_o       out  registered PWM outputs
//   period_end  out  one-cycle pulse, one cycle after each boundary tick
// -----------------------------------------------------------------------------
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [CH_NUM*CNT_W-1:0] duty,
    input  logic                    duty_wr,
    output logic [CH_NUM-1:0]       pwm_o,
    output logic                    period_end
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             tick;
    logic             boundary;
    logic             load_act;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pact_q;
    logic             period_end_q;

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;
    logic [0:0] dir_q, dir_d;
`endif

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Period counter and boundary detection. cnt_q never exceeds pact_q:
    // pact_q only changes when cnt_q is (or is about to become) 0.
    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d    = dir_q;
`endif
        if (!en) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = DIR_UP;
`endif
        end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (dir_q == DIR_UP) begin
                if (cnt_q == pact_q) begin
                    if (pact_q == '0) begin
                        boundary = 1'b1;          // degenerate: stay at 0
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        // With P=1 the turn at the top is already the 1->0 step.
                        if (cnt_q == CNT_ONE) begin
                            boundary = 1'b1;
                        end else begin
                            dir_d = DIR_DOWN;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    boundary = 1'b1;
                    dir_d    = DIR_UP;
                end
            end
`else
            if (cnt_q == pact_q) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
`endif
        end
    end

    // Active registers follow the inputs continuously while idle, so the
    // first period after en rises already uses current values.
    assign load_act = !en || boundary;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            pact_q       <= '0;
            period_end_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q        <= DIR_UP;
`endif
        end else begin
            cnt_q        <= cnt_d;
            period_end_q <= boundary;
            if (load_act) begin
                pact_q <= period;
            end
`ifdef PWM_CENTER_ALIGN_EN
            dir_q        <= dir_d;
`endif
        end
    end

    assign period_end = period_end_q;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] act_q;
        logic             pwm_q;

        // NOTE: the duty register banks are reset explicitly; after reset the
        // outputs must be defined low, not whatever the flops powered up as.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_q <= '0;
                act_q    <= '0;
                pwm_q    <= 1'b0;
            end else begin
                if (duty_wr) begin
                    shadow_q <= duty[chan_lsb(i, CNT_W) +: CNT_W];
                end
                // A write coinciding with a load is seen by act_q one period late.
                if (load_act) begin
                    act_q <= shadow_q;
                end
                pwm_q <= en && (cnt_q < act_q);
            end
        end

        assign pwm_o[i] = pwm_q;
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
// Directed bench for pwm_multi_channel (default edge-aligned build).
// Observation index m counts rising edges after en rises; the output seen
// after edge m reflects the counter value cnt = (m / (prescale+1)) mod (P+1),
// so a channel is high when (m mod period_cycles) < high_cycles and
// period_end is high when (m mod period_cycles) == period_cycles-1.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

    localparam int CH_NUM     = 4;
    localparam int CNT_W      = 8;
    localparam int PRESCALE_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic [PRESCALE_W-1:0]   prescale;
    logic [CNT_W-1:0]        period;
    logic [CH_NUM*CNT_W-1:0] duty;
    logic                    duty_wr;
    logic [CH_NUM-1:0]       pwm_o;
    logic                    period_end;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .CH_NUM     (CH_NUM),
        .CNT_W      (CNT_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .prescale   (prescale),
        .period     (period),
        .duty       (duty),
        .duty_wr    (duty_wr),
        .pwm_o      (pwm_o),
        .period_end (period_end)
    );

    typedef struct packed {
        logic [15:0]     prescale;
        logic [7:0]      period;
        logic [3:0][7:0] duty;   // [3]=ch3 ... [0]=ch0
        logic [3:0][7:0] hi;     // expected high cycles per period, per channel
        logic [7:0]      len;    // expected period length in clk cycles
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_pwm(input logic [3:0][7:0] hi, input int len, input int m);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = ((m % len) < int'(hi[i]));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Load a configuration while idle, let the active registers settle, then
    // raise en so that the next rising edge is observation 0.
    task automatic apply_cfg(input logic [15:0] ps, input logic [7:0] p, input logic [31:0] d);
        en       = 1'b0;
        prescale = ps;
        period   = p;
        duty     = d;
        duty_wr  = 1'b1;
        step();
        duty_wr = 1'b0;
        step();
        step();
        en = 1'b1;
    endtask

    initial begin
        logic [3:0] e;
        int         hi0;

        // Directed vectors with hand-computed high times and period lengths.
        vecs[0] = '{prescale: 16'd0, period: 8'd9, duty: {8'd0, 8'd0, 8'd0, 8'd3},
                    hi: {8'd0, 8'd0, 8'd0, 8'd3}, len: 8'd10};
        vecs[1] = '{prescale: 16'd0, period: 8'd9, duty: {8'd255, 8'd10, 8'd5, 8'd0},
                    hi: {8'd10, 8'd10, 8'd5, 8'd0}, len: 8'd10};
        vecs[2] = '{prescale: 16'd3, period: 8'd4, duty: {8'd1, 8'd5, 8'd0, 8'd2},
                    hi: {8'd4, 8'd20, 8'd0, 8'd8}, len: 8'd20};
        vecs[3] = '{prescale: 16'd1, period: 8'd0, duty: {8'd0, 8'd2, 8'd1, 8'd0},
                    hi: {8'd0, 8'd2, 8'd2, 8'd0}, len: 8'd2};

        rst_n    = 1'b0;
        en       = 1'b1;
        prescale = '0;
        period   = 8'd9;
        duty     = {24'd0, 8'd3};
        duty_wr  = 1'b0;

        // Reset held with en high: outputs stay low throughout.
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("reset pwm c%0d", k), {4'b0, pwm_o}, 8'h00);
            check($sformatf("reset pend c%0d", k), {7'b0, period_end}, 8'h00);
        end
        rst_n = 1'b1;

        // Table-driven steady-state patterns, two full periods per row.
        for (int v = 0; v < 4; v++) begin
            apply_cfg(vecs[v].prescale, vecs[v].period, vecs[v].duty);
            for (int m = 0; m < 2 * int'(vecs[v].len); m++) begin
                step();
                e = exp_pwm(vecs[v].hi, int'(vecs[v].len), m);
                check($sformatf("vec%0d pwm m%0d", v, m), {4'b0, pwm_o}, {4'b0, e});
                check($sformatf("vec%0d pend m%0d", v, m), {7'b0, period_end},
                      {7'b0, (m % int'(vecs[v].len)) == int'(vecs[v].len) - 1});
            end
        end

        // Double buffer: write mid-period (3->7), then a write landing on the
        // boundary edge (7->5) that takes effect one period later; then en
        // drops mid-period while a new period/duty is programmed.
        apply_cfg(16'd0, 8'd9, {24'd0, 8'd3});
        for (int m = 0; m < 46; m++) begin
            step();
            if (m < 43) begin
                case (m / 10)
                    0:       hi0 = 3;
                    1, 2:    hi0 = 7;
                    default: hi0 = 5;
                endcase
                check($sformatf("dbuf pwm m%0d", m), {4'b0, pwm_o}, {7'b0, (m % 10) < hi0});
                check($sformatf("dbuf pend m%0d", m), {7'b0, period_end}, {7'b0, (m % 10) == 9});
            end else begin
                check($sformatf("en_off pwm m%0d", m), {4'b0, pwm_o}, 8'h00);
                check($sformatf("en_off pend m%0d", m), {7'b0, period_end}, 8'h00);
            end
            duty_wr = (m == 4) || (m == 18) || (m == 42);
            if (m == 4)  duty = {24'd0, 8'd7};
            if (m == 18) duty = {24'd0, 8'd5};
            if (m == 42) begin
                en     = 1'b0;
                period = 8'd4;
                duty   = {24'd0, 8'd2};
            end
            if (m == 45) en = 1'b1;
        end

        // First period after en rises uses P=4 and duty 2, starting at cnt 0.
        for (int n = 0; n < 4; n++) begin
            step();
            check($sformatf("en_on pwm n%0d", n), {4'b0, pwm_o}, {7'b0, (n % 5) < 2});
            check($sformatf("en_on pend n%0d", n), {7'b0, period_end}, {7'b0, (n % 5) == 4});
        end

        // Reset mid-period: suppresses the boundary pulse and the next high.
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("midrst pwm k%0d", k), {4'b0, pwm_o}, 8'h00);
            check($sformatf("midrst pend k%0d", k), {7'b0, period_end}, 8'h00);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
